// File: rtl/hmc835_pkg.sv
// Shared definitions for the HMC835-style 32-bit SPI link: frame geometry, field
// positions and the link state type used by both the target and master-side drivers.
package hmc835_pkg;

    localparam int FRAME_BITS = 32;
    localparam int DATA_W     = 24;
    localparam int ADDR_W     = 5;
    localparam int CHIP_W     = 3;
    localparam int CNT_W      = 6;

    localparam int DATA_MSB = FRAME_BITS - 1;
    localparam int DATA_LSB = FRAME_BITS - DATA_W;
    localparam int ADDR_MSB = DATA_LSB - 1;
    localparam int ADDR_LSB = CHIP_W;
    localparam int CHIP_MSB = CHIP_W - 1;
    localparam int CHIP_LSB = 0;

    typedef enum logic {
        LINK_IDLE,
        LINK_FRAME
    } link_state_e;

    // Field order matches the wire order: data first, chip select field last.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [CHIP_W-1:0] chip;
    } frame_t;

    function automatic logic addrInRange(input logic [ADDR_W-1:0] addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin, with rise/fall detection taken from the
// last two synchronized samples.
module spi_pin_sync #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] syncChain_q;
    logic              prevLevel_q;

    // History is preset to the idle level so reset release never looks like an edge.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            syncChain_q <= {STAGES{IDLE_LEVEL}};
            prevLevel_q <= IDLE_LEVEL;
        end else begin
            syncChain_q <= {syncChain_q[STAGES-2:0], pin_i};
            prevLevel_q <= syncChain_q[STAGES-1];
        end
    end

    assign level_o = syncChain_q[STAGES-1];
    assign rise_o  = level_o & ~prevLevel_q;
    assign fall_o  = ~level_o & prevLevel_q;

endmodule

// File: rtl/hmc835_spi_target.sv
// SPI target for the HMC835-style link: oversampled frame decode, local register file
// with write commit strobes, and pointer-based readback on miso.
module hmc835_spi_target
    import hmc835_pkg::*;
#(
    parameter logic [CHIP_W-1:0] CHIP_ID     = 3'd0,
    parameter int                NREGS       = 32,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              sck_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              wr_valid_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              frame_err_o
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic sckLevel, sckRise, sckFall;
    logic csLevel, csRise, csFall;
    logic mosiLevel, mosiRiseUnused, mosiFallUnused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) sckSync (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .pin_i(sck_i),
        .level_o(sckLevel), .rise_o(sckRise), .fall_o(sckFall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) csSync (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .pin_i(cs_i),
        .level_o(csLevel), .rise_o(csRise), .fall_o(csFall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) mosiSync (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .pin_i(mosi_i),
        .level_o(mosiLevel), .rise_o(mosiRiseUnused), .fall_o(mosiFallUnused)
    );

    link_state_e             state_q, state_d;
    logic [CNT_W-1:0]        bitCnt_q, bitCnt_d;
    logic [FRAME_BITS-1:0]   rxShift_q, rxShift_d;
    logic [FRAME_BITS-1:0]   txShift_q, txShift_d;
    logic                    miso_q, miso_d;
    logic                    frameErr_q, frameErr_d;
    logic                    pendValid_q, pendValid_d;
    logic [ADDR_W-1:0]       pendAddr_q, pendAddr_d;
    logic [DATA_W-1:0]       pendData_q, pendData_d;
    logic                    armed_q, armed_d;
    logic [7:0]              primeCnt_q, primeCnt_d;
    logic                    wrValid_q;
    logic [ADDR_W-1:0]       wrAddr_q;
    logic [DATA_W-1:0]       wrData_q;
    logic [ADDR_W-1:0]       readPtr_q;
    logic [DATA_W-1:0]       regFile_q [NREGS];

    frame_t                  rxFrame;
    logic                    primed, sckRiseAct, sckFallAct;
    logic [ADDR_W-1:0]       ptrEff;
    logic [DATA_W-1:0]       loadData;

    assign rxFrame    = rxShift_q;
    assign sckRiseAct = sckRise & ~csLevel & sckLevel;
    assign sckFallAct = sckFall & ~csLevel;
    assign primed     = int'(primeCnt_q) >= SYNC_STAGES;

    // A commit still in flight overrides the stored pointer and data, so a frame that
    // starts in the same clock as a commit already sees the new contents.
    always_comb begin
        ptrEff = readPtr_q;
        if (pendValid_q && pendAddr_q == '0) ptrEff = pendData_q[ADDR_W-1:0];
        loadData = '0;
        if (pendValid_q && pendAddr_q == ptrEff) loadData = pendData_q;
        else if (addrInRange(ptrEff, NREGS)) loadData = regFile_q[ptrEff[IDX_W-1:0]];
    end

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        rxShift_d   = rxShift_q;
        txShift_d   = txShift_q;
        miso_d      = miso_q;
        frameErr_d  = 1'b0;
        pendValid_d = 1'b0;
        pendAddr_d  = pendAddr_q;
        pendData_d  = pendData_q;
        primeCnt_d  = primed ? primeCnt_q : primeCnt_q + 8'd1;
        armed_d     = armed_q | (primed & csLevel);
        unique case (state_q)
            LINK_IDLE: begin
                // Only a falling cs seen after a genuine idle level opens a frame.
                if (csFall && armed_q) begin
                    state_d   = LINK_FRAME;
                    bitCnt_d  = '0;
                    txShift_d = {loadData, {DATA_LSB{1'b0}}};
                    miso_d    = loadData[DATA_W-1];
                end
            end
            LINK_FRAME: begin
                if (csRise) begin
                    state_d = LINK_IDLE;
                    miso_d  = 1'b0;
                    if (bitCnt_q == CNT_W'(FRAME_BITS)) begin
                        if (rxFrame.chip == CHIP_ID && addrInRange(rxFrame.addr, NREGS)) begin
                            pendValid_d = 1'b1;
                            pendAddr_d  = rxFrame.addr;
                            pendData_d  = rxFrame.data;
                        end
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end else if (sckRiseAct) begin
                    rxShift_d = {rxShift_q[FRAME_BITS-2:0], mosiLevel};
                    if (bitCnt_q != '1) bitCnt_d = bitCnt_q + 1'b1;
                end else if (sckFallAct) begin
                    txShift_d = {txShift_q[FRAME_BITS-2:0], 1'b0};
                    miso_d    = txShift_q[FRAME_BITS-2];
                end
            end
            default: state_d = LINK_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q     <= LINK_IDLE;
            bitCnt_q    <= '0;
            rxShift_q   <= '0;
            txShift_q   <= '0;
            miso_q      <= 1'b0;
            frameErr_q  <= 1'b0;
            pendValid_q <= 1'b0;
            pendAddr_q  <= '0;
            pendData_q  <= '0;
            armed_q     <= 1'b0;
            primeCnt_q  <= '0;
            wrValid_q   <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            readPtr_q   <= '0;
            for (int i = 0; i < NREGS; i++) regFile_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            rxShift_q   <= rxShift_d;
            txShift_q   <= txShift_d;
            miso_q      <= miso_d;
            frameErr_q  <= frameErr_d;
            pendValid_q <= pendValid_d;
            pendAddr_q  <= pendAddr_d;
            pendData_q  <= pendData_d;
            armed_q     <= armed_d;
            primeCnt_q  <= primeCnt_d;
            wrValid_q   <= pendValid_q;
            wrAddr_q    <= pendAddr_q;
            wrData_q    <= pendData_q;
            if (pendValid_q) begin
                regFile_q[pendAddr_q[IDX_W-1:0]] <= pendData_q;
                if (pendAddr_q == '0) readPtr_q <= pendData_q[ADDR_W-1:0];
            end
        end
    end

    assign miso_o      = miso_q;
    assign wr_valid_o  = wrValid_q;
    assign wr_addr_o   = wrAddr_q;
    assign wr_data_o   = wrData_q;
    assign frame_err_o = frameErr_q;
    assign rd_data_o   = addrInRange(rd_addr_i, NREGS) ? regFile_q[rd_addr_i[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_hmc835_spi_target.sv
// Scoreboard bench for hmc835_spi_target: a bit-banged SPI master drives frames,
// a forked monitor checks every wr_valid / frame_err against the expected queue.
module tb_hmc835_spi_target;

    typedef struct packed {
        logic        isErr;
        logic [4:0]  addr;
        logic [23:0] data;
    } expEvent_t;

    logic        clock;
    logic        resetN;
    logic        sckPin, csPin, mosiPin;
    logic        misoPin;
    logic        wrValid;
    logic [4:0]  wrAddr;
    logic [23:0] wrData;
    logic [4:0]  rdAddr;
    logic [23:0] rdData;
    logic        frameErr;

    int          checks;
    int          failures;
    expEvent_t   expQ[$];
    logic [31:0] captured;

    hmc835_spi_target #(.CHIP_ID(3'd0), .NREGS(8), .SYNC_STAGES(2)) dut (
        .clock_i(clock), .reset_n_i(resetN), .sck_i(sckPin), .cs_i(csPin),
        .mosi_i(mosiPin), .miso_o(misoPin), .wr_valid_o(wrValid), .wr_addr_o(wrAddr),
        .wr_data_o(wrData), .rd_addr_i(rdAddr), .rd_data_o(rdData), .frame_err_o(frameErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic pushWrite(input logic [4:0] addr, input logic [23:0] data);
        expEvent_t ev;
        ev.isErr = 1'b0;
        ev.addr  = addr;
        ev.data  = data;
        expQ.push_back(ev);
    endtask

    task automatic pushErr();
        expEvent_t ev;
        ev.isErr = 1'b1;
        ev.addr  = '0;
        ev.data  = '0;
        expQ.push_back(ev);
    endtask

    // Master side: miso is sampled just before each falling sck, mosi changes on it.
    task automatic applyStimulus(input logic [63:0] bits, input int nbits, input int gap,
                                 input int resetBit, output logic [31:0] cap);
        cap   = '0;
        csPin = 1'b0;
        waitClocks(6);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (resetBit == nbits - 1 - i) begin
                resetN = 1'b0;
                waitClocks(1);
                resetN = 1'b1;
                checkOutput("miso_after_reset", {31'b0, misoPin}, 32'h0);
                checkOutput("wr_valid_after_reset", {31'b0, wrValid}, 32'h0);
                checkOutput("frame_err_after_reset", {31'b0, frameErr}, 32'h0);
            end
            cap     = {cap[30:0], misoPin};
            sckPin  = 1'b0;
            mosiPin = bits[i];
            waitClocks(4);
            sckPin  = 1'b1;
            waitClocks(4);
        end
        csPin = 1'b1;
        waitClocks(gap);
    endtask

    task automatic checkReg(input string name, input logic [4:0] addr, input logic [23:0] expected);
        rdAddr = addr;
        #1;
        checkOutput(name, {8'h0, rdData}, {8'h0, expected});
    endtask

    task automatic monitorLoop();
        expEvent_t ev;
        forever begin
            @(negedge clock);
            if (resetN) begin
                if (wrValid) begin
                    checks++;
                    if (expQ.size() == 0 || expQ[0].isErr) begin
                        failures++;
                        $display("[TB] FAIL wr_commit: got addr=%0d data=%h, required no commit", wrAddr, wrData);
                    end else begin
                        ev = expQ.pop_front();
                        if (wrAddr !== ev.addr || wrData !== ev.data) begin
                            failures++;
                            $display("[TB] FAIL wr_commit: got addr=%0d data=%h, required addr=%0d data=%h",
                                     wrAddr, wrData, ev.addr, ev.data);
                        end
                    end
                end
                if (frameErr) begin
                    checks++;
                    if (expQ.size() == 0 || !expQ[0].isErr) begin
                        failures++;
                        $display("[TB] FAIL frame_err: got pulse, required none");
                    end else begin
                        ev = expQ.pop_front();
                    end
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetN   = 1'b0;
        csPin    = 1'b1;
        sckPin   = 1'b1;
        mosiPin  = 1'b0;
        rdAddr   = '0;
        waitClocks(3);
        resetN = 1'b1;
        waitClocks(6);
        checkOutput("reset_miso", {31'b0, misoPin}, 32'h0);
        checkOutput("reset_wr_valid", {31'b0, wrValid}, 32'h0);
        checkOutput("reset_frame_err", {31'b0, frameErr}, 32'h0);
        checkReg("reset_reg3", 5'd3, 24'h0);
        fork
            monitorLoop();
        join_none

        $display("[TB] write ABCDEF to reg 3");
        pushWrite(5'd3, 24'hABCDEF);
        applyStimulus({32'h0, 24'hABCDEF, 5'd3, 3'd0}, 32, 12, -1, captured);
        checkReg("reg3_after_write", 5'd3, 24'hABCDEF);

        $display("[TB] pointer readback of reg 5");
        pushWrite(5'd5, 24'h123456);
        applyStimulus({32'h0, 24'h123456, 5'd5, 3'd0}, 32, 12, -1, captured);
        pushWrite(5'd0, 24'h000005);
        applyStimulus({32'h0, 24'h000005, 5'd0, 3'd0}, 32, 12, -1, captured);
        pushWrite(5'd0, 24'h000000);
        applyStimulus(64'h0, 32, 12, -1, captured);
        checkOutput("miso_readback_reg5", captured, 32'h12345600);

        $display("[TB] chip mismatch is dropped");
        applyStimulus({32'h0, 24'h111111, 5'd3, 3'd1}, 32, 12, -1, captured);
        checkReg("reg3_after_chip_mismatch", 5'd3, 24'hABCDEF);

        $display("[TB] address beyond depth is ignored");
        applyStimulus({32'h0, 24'h999999, 5'd9, 3'd0}, 32, 12, -1, captured);
        checkReg("rd_out_of_range", 5'd9, 24'h0);
        pushWrite(5'd7, 24'h777777);
        applyStimulus({32'h0, 24'h777777, 5'd7, 3'd0}, 32, 12, -1, captured);
        checkReg("reg7_top_entry", 5'd7, 24'h777777);

        $display("[TB] short and long frames");
        pushErr();
        applyStimulus(64'h00000000000FFFFF, 20, 12, -1, captured);
        pushErr();
        applyStimulus({31'h0, 33'h1FFFFFFF8}, 33, 12, -1, captured);
        pushWrite(5'd4, 24'h0F0F0F);
        applyStimulus({32'h0, 24'h0F0F0F, 5'd4, 3'd0}, 32, 12, -1, captured);
        checkReg("reg4_after_err_frames", 5'd4, 24'h0F0F0F);
        checkReg("reg3_after_err_frames", 5'd3, 24'hABCDEF);

        $display("[TB] reset in the middle of a frame");
        applyStimulus({32'h0, 24'hDEAD01, 5'd6, 3'd0}, 32, 12, 16, captured);
        checkReg("reg3_cleared", 5'd3, 24'h0);
        checkReg("reg7_cleared", 5'd7, 24'h0);
        checkReg("reg6_not_written", 5'd6, 24'h0);
        pushWrite(5'd6, 24'h0000A5);
        applyStimulus({32'h0, 24'h0000A5, 5'd6, 3'd0}, 32, 12, -1, captured);
        checkReg("reg6_after_reset_frame", 5'd6, 24'h0000A5);

        $display("[TB] back-to-back frames");
        pushWrite(5'd1, 24'h000111);
        applyStimulus({32'h0, 24'h000111, 5'd1, 3'd0}, 32, 4, -1, captured);
        pushWrite(5'd2, 24'h000222);
        applyStimulus({32'h0, 24'h000222, 5'd2, 3'd0}, 32, 12, -1, captured);
        checkReg("reg1_back_to_back", 5'd1, 24'h000111);
        checkReg("reg2_back_to_back", 5'd2, 24'h000222);

        $display("[TB] readback through a dropped frame");
        pushWrite(5'd0, 24'h000002);
        applyStimulus({32'h0, 24'h000002, 5'd0, 3'd0}, 32, 12, -1, captured);
        applyStimulus({32'h0, 24'h000000, 5'd0, 3'd1}, 32, 12, -1, captured);
        checkOutput("miso_readback_reg2", captured, 32'h00022200);
        checkOutput("miso_idle", {31'b0, misoPin}, 32'h0);

        waitClocks(20);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
